// File: rtl/int_ctrl_if.sv
// Bundle of SFR inputs, CPU handshake and TCON clear pulses for the interrupt arbiter.
// The master side is the CPU/SFR block; int_ctrl takes the slave side.
interface int_ctrl_if;
    logic [7:0] ie_data;
    logic [7:0] ip_data;
    logic       ie0;
    logic       tf0;
    logic       ie1;
    logic       tf1;
    logic       ri;
    logic       ti;
    logic       it0;
    logic       it1;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [7:0] int_vect;
    logic [1:0] in_service;
    logic       clr_ie0;
    logic       clr_tf0;
    logic       clr_ie1;
    logic       clr_tf1;

    modport master (
        output ie_data, ip_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1, int_ack, reti,
        input  int_req, int_vect, in_service, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );

    modport slave (
        input  ie_data, ip_data, ie0, tf0, ie1, tf1, ri, ti, it0, it1, int_ack, reti,
        output int_req, int_vect, in_service, clr_ie0, clr_tf0, clr_ie1, clr_tf1
    );
endinterface

// File: rtl/int_ctrl.sv
// Two-level 8051 interrupt arbiter: picks the best eligible source, requests a vector,
// tracks in-service nesting until RETI and pulses TCON flag clears on acknowledge.
module int_ctrl (
    input  logic        clock,
    input  logic        reset,
    int_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t     state_q;
    logic       int_req_q;
    logic [7:0] int_vect_q;
    logic       lvl_q;
    logic [2:0] src_q;
    logic [1:0] in_service_q;
    logic [1:0] in_service_d;
    logic [3:0] clr_q;

    logic       ea;
    logic [4:0] flag;
    logic [4:0] cand;
    logic [4:0] hi_elig;
    logic [4:0] lo_elig;
    logic [4:0] sel_vec;
    logic       sel_lvl;
    logic [2:0] sel_src;
    logic [3:0] clr_en;
    logic       unused_bits;

    assign ea   = bus.ie_data[7];
    // Bit index is the fixed priority order; vector address follows as {src, 3'b011}.
    assign flag = {bus.ri | bus.ti, bus.tf1, bus.ie1, bus.tf0, bus.ie0};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_src
            assign cand[gi]    = flag[gi] & bus.ie_data[gi] & ea;
            assign hi_elig[gi] = cand[gi] & bus.ip_data[gi] & ~in_service_q[1];
            assign lo_elig[gi] = cand[gi] & ~bus.ip_data[gi] & ~(|in_service_q);
        end
    endgenerate

    assign sel_lvl = |hi_elig;
    assign sel_vec = sel_lvl ? hi_elig : lo_elig;

    always_comb begin
        sel_src = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (sel_vec[i]) begin
                sel_src = 3'(i);
            end
        end
    end

    // Edge-triggered externals and timers get hardware clears; serial never does.
    assign clr_en = {1'b1, bus.it1, 1'b1, bus.it0};

    // RETI retires the innermost level before an acknowledge in the same cycle marks a new one.
    always_comb begin
        in_service_d = in_service_q;
        if (bus.reti) begin
            if (in_service_d[1]) begin
                in_service_d[1] = 1'b0;
            end else begin
                in_service_d[0] = 1'b0;
            end
        end
        if (state_q == REQ && bus.int_ack) begin
            in_service_d[lvl_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            int_vect_q   <= 8'h00;
            lvl_q        <= 1'b0;
            src_q        <= 3'd0;
            in_service_q <= 2'b00;
            clr_q        <= 4'b0000;
        end else begin
            clr_q        <= 4'b0000;
            in_service_q <= in_service_d;
            case (state_q)
                IDLE: begin
                    if (|sel_vec) begin
                        state_q    <= REQ;
                        int_req_q  <= 1'b1;
                        int_vect_q <= {2'b00, sel_src, 3'b011};
                        lvl_q      <= sel_lvl;
                        src_q      <= sel_src;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        state_q   <= IDLE;
                        int_req_q <= 1'b0;
                        if (!src_q[2] && clr_en[src_q[1:0]]) begin
                            clr_q[src_q[1:0]] <= 1'b1;
                        end
                    end else if (!ea) begin
                        state_q   <= IDLE;
                        int_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    int_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vect   = int_vect_q;
    assign bus.in_service = in_service_q;
    assign bus.clr_ie0    = clr_q[0];
    assign bus.clr_tf0    = clr_q[1];
    assign bus.clr_ie1    = clr_q[2];
    assign bus.clr_tf1    = clr_q[3];

    assign unused_bits = ^{bus.ie_data[6:5], bus.ip_data[7:5]};
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, async reset check, then random stimulus
// compared cycle by cycle against a rule-level reference model.
module tb_int_ctrl;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] ie;
        logic [7:0] ip;
        logic [5:0] flg;   // {ie0, tf0, ie1, tf1, ri, ti}
        logic [1:0] it;    // {it1, it0}
        logic       ack;
        logic       reti;
        logic       req;
        logic [7:0] vect;
        logic [1:0] is;
        logic [3:0] clr;   // {tf1, ie1, tf0, ie0}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] ie, input logic [7:0] ip, input logic [5:0] flg,
                                input logic [1:0] it, input logic ack, input logic reti,
                                input logic req, input logic [7:0] vect, input logic [1:0] is,
                                input logic [3:0] clr);
        vec_t v;
        v.ie = ie; v.ip = ip; v.flg = flg; v.it = it; v.ack = ack; v.reti = reti;
        v.req = req; v.vect = vect; v.is = is; v.clr = clr;
        return v;
    endfunction

    function automatic logic [3:0] dut_clr();
        return {bus.clr_tf1, bus.clr_ie1, bus.clr_tf0, bus.clr_ie0};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ie, input logic [7:0] ip, input logic [5:0] flg,
                         input logic [1:0] it, input logic ack, input logic reti);
        bus.ie_data = ie;
        bus.ip_data = ip;
        {bus.ie0, bus.tf0, bus.ie1, bus.tf1, bus.ri, bus.ti} = flg;
        {bus.it1, bus.it0} = it;
        bus.int_ack = ack;
        bus.reti = reti;
    endtask

    // Reference model state
    logic       m_req;
    logic [7:0] m_vect;
    logic       m_lvl;
    int         m_src;
    logic [1:0] m_is;
    logic [3:0] m_clr;

    task automatic model_step();
        logic       f[5];
        logic       n_req;
        logic [7:0] n_vect;
        logic       n_lvl;
        int         n_src;
        logic [1:0] n_is;
        logic [3:0] n_clr;
        int         best;
        logic       blvl;
        f[0] = bus.ie0; f[1] = bus.tf0; f[2] = bus.ie1; f[3] = bus.tf1; f[4] = bus.ri | bus.ti;
        n_req = m_req; n_vect = m_vect; n_lvl = m_lvl; n_src = m_src; n_clr = 4'b0000;
        n_is = m_is;
        if (bus.reti) begin
            if (n_is[1]) n_is[1] = 1'b0;
            else n_is[0] = 1'b0;
        end
        if (!m_req) begin
            best = -1;
            blvl = 1'b0;
            for (int lv = 1; lv >= 0; lv--) begin
                for (int i = 0; i < 5; i++) begin
                    if (best < 0 && f[i] && bus.ie_data[i] && bus.ie_data[7] &&
                        (bus.ip_data[i] == lv[0]) &&
                        ((lv == 1) ? (m_is[1] == 1'b0) : (m_is == 2'b00))) begin
                        best = i;
                        blvl = lv[0];
                    end
                end
            end
            if (best >= 0) begin
                n_req = 1'b1;
                n_vect = 8'h03 + 8'(8 * best);
                n_lvl = blvl;
                n_src = best;
            end
        end else if (bus.int_ack) begin
            n_req = 1'b0;
            n_is[m_lvl] = 1'b1;
            if ((m_src == 0 && bus.it0) || m_src == 1 || (m_src == 2 && bus.it1) || m_src == 3)
                n_clr[m_src] = 1'b1;
        end else if (!bus.ie_data[7]) begin
            n_req = 1'b0;
        end
        m_req = n_req; m_vect = n_vect; m_lvl = n_lvl; m_src = n_src; m_is = n_is; m_clr = n_clr;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        drive(8'h00, 8'h00, 6'b0, 2'b00, 1'b0, 1'b0);
        #23;
        reset = 1'b0;
        #3;
        chk("rst_req", 0, {7'b0, bus.int_req}, 8'h00);
        chk("rst_vect", 0, bus.int_vect, 8'h00);
        chk("rst_is", 0, {6'b0, bus.in_service}, 8'h00);
        chk("rst_clr", 0, {4'b0, dut_clr()}, 8'h00);

        //          ie     ip     flg        it     ack   reti  req   vect   is     clr
        tbl.push_back(mk(8'h81, 8'h00, 6'b100000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h03, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h81, 8'h00, 6'b100000, 2'b01, 1'b1, 1'b0, 1'b0, 8'h03, 2'b01, 4'b0001));
        tbl.push_back(mk(8'h81, 8'h00, 6'b000000, 2'b01, 1'b0, 1'b0, 1'b0, 8'h03, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h81, 8'h00, 6'b000000, 2'b01, 1'b0, 1'b1, 1'b0, 8'h03, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100110, 2'b01, 1'b0, 1'b0, 1'b1, 8'h1B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100110, 2'b01, 1'b1, 1'b0, 1'b0, 8'h1B, 2'b10, 4'b1000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100110, 2'b01, 1'b0, 1'b0, 1'b0, 8'h1B, 2'b10, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100110, 2'b01, 1'b0, 1'b0, 1'b0, 8'h1B, 2'b10, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100010, 2'b01, 1'b0, 1'b1, 1'b0, 8'h1B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100010, 2'b01, 1'b0, 1'b0, 1'b1, 8'h03, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b100010, 2'b01, 1'b1, 1'b0, 1'b0, 8'h03, 2'b01, 4'b0001));
        tbl.push_back(mk(8'h9F, 8'h08, 6'b000000, 2'b01, 1'b0, 1'b1, 1'b0, 8'h03, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h8F, 8'h00, 6'b010000, 2'b00, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h8F, 8'h00, 6'b010000, 2'b00, 1'b1, 1'b0, 1'b0, 8'h0B, 2'b01, 4'b0010));
        tbl.push_back(mk(8'h8F, 8'h04, 6'b001000, 2'b10, 1'b0, 1'b0, 1'b1, 8'h13, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h8F, 8'h04, 6'b001000, 2'b10, 1'b1, 1'b0, 1'b0, 8'h13, 2'b11, 4'b0100));
        tbl.push_back(mk(8'h8F, 8'h04, 6'b000000, 2'b10, 1'b0, 1'b1, 1'b0, 8'h13, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h8F, 8'h04, 6'b000000, 2'b10, 1'b0, 1'b1, 1'b0, 8'h13, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b001000, 2'b00, 1'b0, 1'b0, 1'b1, 8'h13, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b001000, 2'b00, 1'b1, 1'b0, 1'b0, 8'h13, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b0, 8'h13, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b000010, 2'b11, 1'b0, 1'b0, 1'b1, 8'h23, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b000010, 2'b11, 1'b1, 1'b0, 1'b0, 8'h23, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h9F, 8'h00, 6'b000000, 2'b11, 1'b0, 1'b1, 1'b0, 8'h23, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h82, 8'h00, 6'b010000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h02, 8'h00, 6'b010000, 2'b01, 1'b0, 1'b0, 1'b0, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h02, 8'h00, 6'b000000, 2'b01, 1'b0, 1'b0, 1'b0, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b010000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b110000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b100000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b100000, 2'b01, 1'b1, 1'b0, 1'b0, 8'h0B, 2'b01, 4'b0010));
        tbl.push_back(mk(8'h83, 8'h00, 6'b000000, 2'b01, 1'b0, 1'b1, 1'b0, 8'h0B, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b100000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h03, 2'b00, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h00, 6'b100000, 2'b01, 1'b1, 1'b0, 1'b0, 8'h03, 2'b01, 4'b0001));
        tbl.push_back(mk(8'h83, 8'h02, 6'b010000, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0B, 2'b01, 4'b0000));
        tbl.push_back(mk(8'h83, 8'h02, 6'b010000, 2'b01, 1'b1, 1'b1, 1'b0, 8'h0B, 2'b10, 4'b0010));
        tbl.push_back(mk(8'h83, 8'h02, 6'b000000, 2'b01, 1'b0, 1'b1, 1'b0, 8'h0B, 2'b00, 4'b0000));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].ie, tbl[r].ip, tbl[r].flg, tbl[r].it, tbl[r].ack, tbl[r].reti);
            @(posedge clock);
            #1;
            $display("row %0d: req=%b vect=%h is=%b clr=%b", r, bus.int_req, bus.int_vect,
                     bus.in_service, dut_clr());
            chk("row_req", r, {7'b0, bus.int_req}, {7'b0, tbl[r].req});
            chk("row_vect", r, bus.int_vect, tbl[r].vect);
            chk("row_is", r, {6'b0, bus.in_service}, {6'b0, tbl[r].is});
            chk("row_clr", r, {4'b0, dut_clr()}, {4'b0, tbl[r].clr});
        end

        // Asynchronous reset while a request is pending
        drive(8'h81, 8'h00, 6'b100000, 2'b01, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("arst_pre_req", 0, {7'b0, bus.int_req}, 8'h01);
        bus.int_ack = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        $display("async reset: req=%b vect=%h is=%b clr=%b", bus.int_req, bus.int_vect,
                 bus.in_service, dut_clr());
        chk("arst_req", 0, {7'b0, bus.int_req}, 8'h00);
        chk("arst_vect", 0, bus.int_vect, 8'h00);
        chk("arst_is", 0, {6'b0, bus.in_service}, 8'h00);
        @(posedge clock);
        #1;
        chk("arst_clr", 0, {4'b0, dut_clr()}, 8'h00);
        drive(8'h00, 8'h00, 6'b0, 2'b00, 1'b0, 1'b0);
        #2;
        reset = 1'b0;

        // Random stimulus against the reference model
        m_req = 1'b0; m_vect = 8'h00; m_lvl = 1'b0; m_src = 0; m_is = 2'b00; m_clr = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if (c % 16 == 0) begin
                bus.ie_data = 8'($urandom_range(0, 31)) | (($urandom_range(0, 7) != 0) ? 8'h80 : 8'h00);
                bus.ip_data = 8'($urandom_range(0, 255));
            end
            bus.ie0 = ($urandom_range(0, 2) == 0);
            bus.tf0 = ($urandom_range(0, 2) == 0);
            bus.ie1 = ($urandom_range(0, 2) == 0);
            bus.tf1 = ($urandom_range(0, 2) == 0);
            bus.ri  = ($urandom_range(0, 5) == 0);
            bus.ti  = ($urandom_range(0, 5) == 0);
            bus.it0 = 1'($urandom_range(0, 1));
            bus.it1 = 1'($urandom_range(0, 1));
            bus.int_ack = ($urandom_range(0, 2) == 0);
            bus.reti = ($urandom_range(0, 7) == 0);
            model_step();
            @(posedge clock);
            #1;
            $display("rnd %0d: req=%b vect=%h is=%b clr=%b", c, bus.int_req, bus.int_vect,
                     bus.in_service, dut_clr());
            chk("rnd_req", c, {7'b0, bus.int_req}, {7'b0, m_req});
            chk("rnd_vect", c, bus.int_vect, m_vect);
            chk("rnd_is", c, {6'b0, bus.in_service}, {6'b0, m_is});
            chk("rnd_clr", c, {4'b0, dut_clr()}, {4'b0, m_clr});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Two-level interrupt arbiter for the 8051 core. It sits directly downstream of the IE and IP special-function registers and the TCON/SCON flag bits. It selects the highest-priority enabled pending source and presents a vector request to the CPU control unit. It tracks in-service nesting until RETI and issues hardware flag-clear pulses back to TCON on vectoring.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ie_data  in  8  IE register: [7]=EA, [4]=ES, [3]=ET1, [2]=EX1, [1]=ET0, [0]=EX0
- ip_data  in  8  IP register, same bit positions; 1 = high priority
- ie0, tf0, ie1, tf1  in  1 each  TCON interrupt flags
- ri, ti  in  1 each  SCON serial flags; serial source = ri | ti
- it0, it1  in  1 each  TCON edge/level select; 1 = edge
- int_ack  in  1  one-cycle pulse from CPU: vector accepted, LCALL begins
- reti  in  1  one-cycle pulse from CPU on RETI execution
- int_req  out  1  interrupt request to CPU
- int_vect  out  8  vector address, valid while int_req=1
- in_service  out  2  [1]=high level active, [0]=low level active
- clr_ie0, clr_tf0, clr_ie1, clr_tf1  out  1 each  one-cycle clear pulses to TCON

## Operation
- Source order within a level, highest first:
  - IE0, vector 8'h03
  - TF0, vector 8'h0B
  - IE1, vector 8'h13
  - TF1, vector 8'h1B
  - serial, vector 8'h23
- Candidate: a source is a candidate when its flag = 1, its enable bit = 1 and EA = 1.
- High candidate: a candidate with IP bit = 1. It is eligible when in_service[1] = 0.
- Low candidate: a candidate with IP bit = 0. It is eligible when in_service = 2'b00.
- Selection: any eligible high candidate beats every low candidate. Within a level, fixed order applies.
- FSM states:
  - IDLE: int_req = 0. If any eligible candidate exists, latch its vector and level, then go to REQ.
  - REQ: int_req = 1 and int_vect holds the latched value.
    - On int_ack: set the in-service bit of the latched level, pulse the clear for the latched source, go to IDLE.
    - If EA = 0 and int_ack = 0: cancel and go to IDLE with no side effects.
    - Otherwise hold. The latched vector does not change even if a higher source arrives or the latched flag drops.
- Flag-clear rules:
  - IE0 is cleared only if it0 = 1. IE1 is cleared only if it1 = 1.
  - TF0 and TF1 are always cleared.
  - Serial sources are never cleared; software clears RI/TI.
- RETI: clears in_service[1] if it is set, otherwise in_service[0]. RETI with in_service = 00 has no effect.
- Simultaneous reti and int_ack: reti is applied first, then the ack's set. For example, in_service = 01 with reti and a high ack gives 10.
- reti in any state does not disturb the FSM.

## Timing
- Reset values: state IDLE, int_req = 0, int_vect = 8'h00, in_service = 2'b00, all clr_* = 0.
- Reset mid-REQ drops int_req immediately (asynchronous); no clear pulse is issued.
- Request latency: a candidate visible at rising edge N (inputs sampled) gives int_req = 1 after edge N.
- int_ack sampled at edge M:
  - int_req = 0 and clr_* = 1 after edge M.
  - clr_* = 0 after edge M+1.
  - in_service updates after edge M.
- The earliest next request follows at edge M+1. A new int_req can appear after edge M+1 if eligible.
- After reti at edge R, newly eligible lower-level sources raise int_req after edge R+1.
- int_ack while in IDLE is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic vectoring:
  - Stimulus: reset, then IE = 8'h81, IP = 0, it0 = 1, ie0 = 1.
  - Required: int_req = 1 one cycle later with int_vect = 03. Ack leads to a clr_ie0 one-cycle pulse and in_service = 01.
- Priority:
  - Stimulus: IE = 8'h9F, IP = 8'h08, ie0 = tf1 = ri = 1 simultaneously.
  - Required: vector 1B (high) is requested first.
  - Then: after ack, no request until reti, then vector 03 follows.
- Nesting:
  - Stimulus: low TF0 in service (in_service = 01), then high IE1 with IP = 8'h04.
  - Required: vector 13 is requested. Ack gives in_service = 11. First reti gives 01, second reti gives 00.
- Level-triggered and serial sources:
  - Stimulus 1: it1 = 0, ie1 vectored.
  - Required: clr_ie1 stays 0.
  - Stimulus 2: ri vectored.
  - Required: no clr pulse, vector 23.
- Cancel and hold:
  - Stimulus 1: in REQ with vector 0B, EA cleared before ack.
  - Required: int_req drops next cycle, tf0 is not cleared, in_service is unchanged.
  - Stimulus 2: in REQ with 0B, ie0 raised.
  - Required: int_vect stays 0B until ack.
- Simultaneous events and reset:
  - Stimulus 1: reti and int_ack in the same cycle with in_service = 01 and a latched high request.
  - Required: in_service becomes 10.
  - Stimulus 2: async reset asserted mid-REQ.
  - Required: all outputs return to reset values immediately.
